// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with overflow trapping. The register captures the EX
// instruction on accept. A trapped signed overflow holds an exception request until it is acknowledged.
//
//   state | meaning
//   RUN   | normal flow; ex_ready follows !mem_stall
//   TRAP  | overflow exception pending; EX is stalled until exc_ack
module ex_mem_stage #(
  parameter logic [4:0] EXC_OVF = 5'h0C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_sum,
  input  logic        ex_over,
  input  logic        ex_trap_en,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  input  logic [31:0] ex_store_data,
  input  logic        mem_stall,
  input  logic        flush,
  input  logic        exc_ack,
  output logic        mem_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_we,
  output logic        mem_mem_re,
  output logic        mem_mem_we,
  output logic        exc_req,
  output logic [31:0] exc_pc,
  output logic [4:0]  exc_code,
  output logic [15:0] ovf_count
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t      state_q;
  logic        mem_valid_q;
  logic [31:0] mem_pc_q;
  logic [31:0] mem_alu_result_q;
  logic [31:0] mem_store_data_q;
  logic [4:0]  mem_rd_q;
  logic        mem_reg_we_q;
  logic        mem_mem_re_q;
  logic        mem_mem_we_q;
  logic        exc_req_q;
  logic [31:0] exc_pc_q;
  logic [4:0]  exc_code_q;
  logic [15:0] ovf_count_q;
  logic [15:0] ovf_count_d;

  logic accept;
  logic trap;

  assign ex_ready    = rst_n && (state_q == RUN) && !mem_stall;
  assign accept      = ex_valid && ex_ready && !flush;
  assign trap        = accept && ex_over && ex_trap_en;
  assign ovf_count_d = (ovf_count_q == 16'hFFFF) ? ovf_count_q : ovf_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= RUN;
      mem_valid_q      <= 1'b0;
      mem_pc_q         <= '0;
      mem_alu_result_q <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_reg_we_q     <= 1'b0;
      mem_mem_re_q     <= 1'b0;
      mem_mem_we_q     <= 1'b0;
      exc_req_q        <= 1'b0;
      exc_pc_q         <= '0;
      exc_code_q       <= '0;
      ovf_count_q      <= '0;
    end else if (state_q == RUN) begin
      if (trap) begin
        // The faulting instruction never reaches MEM; its data fields are left as they were.
        state_q      <= TRAP;
        mem_valid_q  <= 1'b0;
        mem_reg_we_q <= 1'b0;
        mem_mem_re_q <= 1'b0;
        mem_mem_we_q <= 1'b0;
        exc_req_q    <= 1'b1;
        exc_pc_q     <= ex_pc;
        exc_code_q   <= EXC_OVF;
        ovf_count_q  <= ovf_count_d;
      end else if (accept) begin
        mem_valid_q      <= 1'b1;
        mem_pc_q         <= ex_pc;
        mem_alu_result_q <= ex_sum;
        mem_store_data_q <= ex_store_data;
        mem_rd_q         <= ex_rd;
        mem_reg_we_q     <= ex_reg_we;
        mem_mem_re_q     <= ex_mem_re;
        mem_mem_we_q     <= ex_mem_we;
      end else if (flush || !mem_stall) begin
        mem_valid_q  <= 1'b0;
        mem_reg_we_q <= 1'b0;
        mem_mem_re_q <= 1'b0;
        mem_mem_we_q <= 1'b0;
      end
    end else if (exc_ack) begin
      state_q   <= RUN;
      exc_req_q <= 1'b0;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_pc         = mem_pc_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_reg_we     = mem_reg_we_q;
  assign mem_mem_re     = mem_mem_re_q;
  assign mem_mem_we     = mem_mem_we_q;
  assign exc_req        = exc_req_q;
  assign exc_pc         = exc_pc_q;
  assign exc_code       = exc_code_q;
  assign ovf_count      = ovf_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, hand sequences for stall/flush/reset/saturation,
// then randomized traffic against a cycle-level behavioural model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, ex_valid, ex_ready, ex_over, ex_trap_en;
  logic [31:0] ex_pc, ex_sum, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_re, ex_mem_we, mem_stall, flush, exc_ack;
  logic        mem_valid, mem_reg_we, mem_mem_re, mem_mem_we, exc_req;
  logic [31:0] mem_pc, mem_alu_result, mem_store_data, exc_pc;
  logic [4:0]  mem_rd, exc_code;
  logic [15:0] ovf_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_sum(ex_sum), .ex_over(ex_over), .ex_trap_en(ex_trap_en), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_store_data(ex_store_data), .mem_stall(mem_stall), .flush(flush), .exc_ack(exc_ack),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
    .mem_mem_re(mem_mem_re), .mem_mem_we(mem_mem_we), .exc_req(exc_req), .exc_pc(exc_pc),
    .exc_code(exc_code), .ovf_count(ovf_count)
  );

  // Behavioural model: the MEM register contents, the pending exception and the trap count.
  bit          m_trap;
  bit          m_valid, m_rwe, m_re, m_we, m_exc;
  logic [31:0] m_pc, m_alu, m_sd, m_epc;
  logic [4:0]  m_rd, m_code;
  int          m_cnt;

  function automatic void model_step();
    bit acc;
    if (!rst_n) begin
      m_trap = 0; m_valid = 0; m_rwe = 0; m_re = 0; m_we = 0; m_exc = 0;
      m_pc = 0; m_alu = 0; m_sd = 0; m_epc = 0; m_rd = 0; m_code = 0; m_cnt = 0;
    end else if (m_trap) begin
      if (exc_ack) begin
        m_trap = 0;
        m_exc  = 0;
      end
    end else begin
      acc = ex_valid && !mem_stall && !flush;
      if (acc && ex_over && ex_trap_en) begin
        m_trap = 1; m_valid = 0; m_rwe = 0; m_re = 0; m_we = 0;
        m_exc = 1; m_epc = ex_pc; m_code = 5'h0C;
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      end else if (acc) begin
        m_valid = 1; m_pc = ex_pc; m_alu = ex_sum; m_sd = ex_store_data; m_rd = ex_rd;
        m_rwe = ex_reg_we; m_re = ex_mem_re; m_we = ex_mem_we;
      end else if (flush || !mem_stall) begin
        m_valid = 0; m_rwe = 0; m_re = 0; m_we = 0;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("mem_valid", 32'(mem_valid), 32'(m_valid));
    chk("mem_reg_we", 32'(mem_reg_we), 32'(m_rwe));
    chk("mem_mem_re", 32'(mem_mem_re), 32'(m_re));
    chk("mem_mem_we", 32'(mem_mem_we), 32'(m_we));
    chk("exc_req", 32'(exc_req), 32'(m_exc));
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    if (m_valid) begin
      chk("mem_pc", mem_pc, m_pc);
      chk("mem_alu_result", mem_alu_result, m_alu);
      chk("mem_store_data", mem_store_data, m_sd);
      chk("mem_rd", 32'(mem_rd), 32'(m_rd));
    end
    if (m_exc) begin
      chk("exc_pc", exc_pc, m_epc);
      chk("exc_code", 32'(exc_code), 32'(m_code));
    end
  endtask

  // One clock: sample ex_ready mid-cycle, let the edge pass, advance the model, compare.
  task automatic tick(input bit chk_all, output logic rdy_seen);
    #2;
    rdy_seen = ex_ready;
    if (chk_all) chk("ex_ready", 32'(ex_ready), 32'(rst_n && !m_trap && !mem_stall));
    @(posedge clk);
    model_step();
    #1;
    if (chk_all) compare_all();
  endtask

  task automatic clear_in();
    rst_n = 1; ex_valid = 0; ex_pc = 0; ex_sum = 0; ex_over = 0; ex_trap_en = 0; ex_rd = 0;
    ex_reg_we = 0; ex_mem_re = 0; ex_mem_we = 0; ex_store_data = 0;
    mem_stall = 0; flush = 0; exc_ack = 0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] sum, input logic ov,
                           input logic ten, input logic [4:0] rd, input logic rwe);
    ex_valid = 1; ex_pc = pc; ex_sum = sum; ex_over = ov; ex_trap_en = ten;
    ex_rd = rd; ex_reg_we = rwe;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] sum;
    logic        over, ten;
    logic [4:0]  rd;
    logic        rwe, stall, fl, ack;
    logic        e_rdy, e_mv;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_rwe, e_exc;
    logic [31:0] e_epc;
    logic [15:0] e_cnt;
    logic        chk_data;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic rdy;
    vt[0] = '{1, 32'h100, 32'h5, 0, 0, 5'd3, 1, 0, 0, 0,  1, 1, 32'h5, 5'd3, 1, 0, 32'h0, 16'd0, 1};
    vt[1] = '{1, 32'h0040_0010, 32'h8000_0000, 1, 1, 5'd4, 1, 0, 0, 0,
              1, 0, 32'h0, 5'd0, 0, 1, 32'h0040_0010, 16'd1, 0};
    vt[2] = '{1, 32'h0040_0010, 32'h8000_0000, 1, 1, 5'd4, 1, 0, 0, 0,
              0, 0, 32'h0, 5'd0, 0, 1, 32'h0040_0010, 16'd1, 0};
    vt[3] = '{0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0, 0, 1,  0, 0, 32'h0, 5'd0, 0, 0, 32'h0, 16'd1, 0};
    vt[4] = '{1, 32'h200, 32'h8000_0000, 1, 0, 5'd7, 1, 0, 0, 0,
              1, 1, 32'h8000_0000, 5'd7, 1, 0, 32'h0, 16'd1, 1};
    vt[5] = '{0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0, 0, 1,  1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 16'd1, 0};
    vt[6] = '{1, 32'h300, 32'h8000_0001, 1, 1, 5'd2, 1, 0, 1, 0,
              1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 16'd1, 0};
    vt[7] = '{1, 32'h304, 32'h0000_DEAD, 0, 0, 5'd1, 1, 0, 0, 0,
              1, 1, 32'h0000_DEAD, 5'd1, 1, 0, 32'h0, 16'd1, 1};

    clear_in();
    rst_n = 0;
    tick(1, rdy);
    tick(1, rdy);
    rst_n = 1;
    tick(1, rdy);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      clear_in();
      ex_valid = vt[i].valid; ex_pc = vt[i].pc; ex_sum = vt[i].sum; ex_over = vt[i].over;
      ex_trap_en = vt[i].ten; ex_rd = vt[i].rd; ex_reg_we = vt[i].rwe;
      mem_stall = vt[i].stall; flush = vt[i].fl; exc_ack = vt[i].ack;
      tick(0, rdy);
      chk($sformatf("v%0d.ex_ready", i), 32'(rdy), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d.mem_valid", i), 32'(mem_valid), 32'(vt[i].e_mv));
      chk($sformatf("v%0d.mem_reg_we", i), 32'(mem_reg_we), 32'(vt[i].e_rwe));
      chk($sformatf("v%0d.exc_req", i), 32'(exc_req), 32'(vt[i].e_exc));
      chk($sformatf("v%0d.ovf_count", i), 32'(ovf_count), 32'(vt[i].e_cnt));
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d.mem_alu_result", i), mem_alu_result, vt[i].e_alu);
        chk($sformatf("v%0d.mem_rd", i), 32'(mem_rd), 32'(vt[i].e_rd));
      end
      if (vt[i].e_exc) begin
        chk($sformatf("v%0d.exc_pc", i), exc_pc, vt[i].e_epc);
        chk($sformatf("v%0d.exc_code", i), 32'(exc_code), 32'h0C);
      end
    end

    // Stall freezes a valid MEM entry; flush in the second stall cycle clears it.
    clear_in();
    set_instr(32'h400, 32'hAAAA_5555, 0, 0, 5'd12, 1);
    ex_mem_we = 1; ex_store_data = 32'h1357_9BDF;
    tick(1, rdy);
    set_instr(32'h404, 32'h1111_2222, 0, 0, 5'd13, 1);
    ex_mem_we = 0;
    mem_stall = 1;
    tick(1, rdy);
    chk("stall1.ex_ready", 32'(rdy), 32'h0);
    chk("stall1.mem_alu_result", mem_alu_result, 32'hAAAA_5555);
    chk("stall1.mem_mem_we", 32'(mem_mem_we), 32'h1);
    flush = 1;
    tick(1, rdy);
    chk("stall2.flush.mem_valid", 32'(mem_valid), 32'h0);
    chk("stall2.flush.mem_mem_we", 32'(mem_mem_we), 32'h0);
    flush = 0;
    tick(1, rdy);
    chk("stall3.mem_valid", 32'(mem_valid), 32'h0);
    mem_stall = 0;
    tick(1, rdy);
    chk("resume.mem_rd", 32'(mem_rd), 32'd13);

    // Reset during TRAP discards the pending exception.
    clear_in();
    set_instr(32'h500, 32'h7FFF_FFFF, 1, 1, 5'd5, 1);
    tick(1, rdy);
    chk("trap.exc_req", 32'(exc_req), 32'h1);
    rst_n = 0;
    tick(1, rdy);
    chk("rst_trap.ex_ready", 32'(rdy), 32'h0);
    chk("rst_trap.exc_req", 32'(exc_req), 32'h0);
    chk("rst_trap.ovf_count", 32'(ovf_count), 32'h0);
    clear_in();
    set_instr(32'h600, 32'h42, 0, 0, 5'd6, 1);
    tick(1, rdy);
    chk("post_rst.ex_ready", 32'(rdy), 32'h1);
    chk("post_rst.mem_valid", 32'(mem_valid), 32'h1);

    // Saturation: preload the counter one below the top, then trap repeatedly.
    clear_in();
    set_instr(32'h700, 32'h8000_0000, 1, 1, 5'd8, 1);
    force dut.ovf_count_q = 16'hFFFE;
    m_cnt = 65534;
    tick(0, rdy);
    chk("sat.trap1.exc_req", 32'(exc_req), 32'h1);
    release dut.ovf_count_q;
    clear_in();
    exc_ack = 1;
    tick(0, rdy);
    chk("sat.ack1.exc_req", 32'(exc_req), 32'h0);
    for (int k = 0; k < 2; k++) begin
      clear_in();
      set_instr(32'h704 + 32'(k), 32'h8000_0000, 1, 1, 5'd8, 1);
      tick(1, rdy);
      chk("sat.ovf_count", 32'(ovf_count), 32'hFFFF);
      clear_in();
      exc_ack = 1;
      tick(1, rdy);
    end

    // Randomized traffic against the model.
    clear_in();
    rst_n = 0;
    tick(1, rdy);
    for (int n = 0; n < 600; n++) begin
      rst_n         = ($urandom_range(99, 0) >= 2);
      ex_valid      = ($urandom_range(99, 0) < 70);
      ex_pc         = $urandom;
      ex_sum        = $urandom;
      ex_over       = ($urandom_range(99, 0) < 30);
      ex_trap_en    = ($urandom_range(99, 0) < 50);
      ex_rd         = 5'($urandom);
      ex_reg_we     = 1'($urandom);
      ex_mem_re     = 1'($urandom);
      ex_mem_we     = 1'($urandom);
      ex_store_data = $urandom;
      mem_stall     = ($urandom_range(99, 0) < 25);
      flush         = ($urandom_range(99, 0) < 10);
      exc_ack       = ($urandom_range(99, 0) < 40);
      tick(1, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
